// File: rtl/booth_multiplier_param_pkg.sv
// Shared definitions for the Booth multiplier and the factorial controller:
// controller state encoding and radix-4 Booth digit codes.
package booth_multiplier_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_DONE    = 2'b10
    } mul_state_t;

    typedef enum logic [2:0] {
        BOOTH_ZERO = 3'd0,
        BOOTH_POS1 = 3'd1,
        BOOTH_POS2 = 3'd2,
        BOOTH_NEG1 = 3'd3,
        BOOTH_NEG2 = 3'd4
    } booth_op_t;

    // Triplet x(2i+1),x(2i),x(2i-1) -> radix-4 digit in {-2,-1,0,+1,+2}
    function automatic booth_op_t booth_decode(input logic [2:0] triplet);
        booth_op_t op_v;
        case (triplet)
            3'b000, 3'b111: op_v = BOOTH_ZERO;
            3'b001, 3'b010: op_v = BOOTH_POS1;
            3'b011:         op_v = BOOTH_POS2;
            3'b100:         op_v = BOOTH_NEG2;
            3'b101, 3'b110: op_v = BOOTH_NEG1;
            default:        op_v = BOOTH_ZERO;
        endcase
        return op_v;
    endfunction

endpackage

// File: rtl/booth_multiplier_param_digit.sv
// One radix-4 Booth digit: selects 0, +/-M or +/-2M from the extended
// multiplicand according to the recoded triplet (two's-complement, modulo 2^MW).
module booth_r4_digit
    import booth_multiplier_param_pkg::*;
#(
    parameter int MW = 130
) (
    input  logic [2:0]    triplet,
    input  logic [MW-1:0] mcand,
    output logic [MW-1:0] pp
);

    booth_op_t op_s;

    // Digit decode and partial-product selection
    always_comb begin
        op_s = booth_decode(triplet);
        pp   = '0;
        case (op_s)
            BOOTH_ZERO: pp = '0;
            BOOTH_POS1: pp = mcand;
            BOOTH_POS2: pp = mcand << 1;
            BOOTH_NEG1: pp = -mcand;
            BOOTH_NEG2: pp = -(mcand << 1);
            default:    pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_multiplier_param.sv
// Sequential radix-4 Booth multiplier, DPC digits retired per EXECUTE cycle,
// with op_start/op_clear/op_done handshake, busy flag and signed/unsigned mode.
module booth_multiplier_param
    import booth_multiplier_param_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DPC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               op_done,
    output logic               op_busy,
    output logic [2*WIDTH-1:0] result
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int ITER = (NDIG + DPC - 1) / DPC;
    localparam int EXT  = 2 * DPC * ITER;
    localparam int MW   = 2 * WIDTH + 2;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(ITER + 1) + 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    mul_state_t    state_r;
    mul_state_t    state_next_s;
    logic [CW-1:0] cnt_r;
    logic [EXT:0]  mplier_r;      // extended multiplier with x(-1) at bit 0
    logic [MW-1:0] mcand_r;       // extended multiplicand, pre-shifted per cycle
    logic [PW-1:0] acc_r;
    logic [PW-1:0] step_sum_s;
    logic [PW-1:0] result_r;
    logic          done_r;
    logic          busy_r;
    logic          mplier_ext_s;
    logic          mcand_ext_s;
    logic [EXT:0]  mplier_load_s;
    logic [MW-1:0] mcand_load_s;
    logic [MW-1:0] pp_s [DPC];

    // Operand extension applied on the latching edge
    always_comb begin
        mplier_ext_s  = signed_mode & multiplier[WIDTH-1];
        mcand_ext_s   = signed_mode & multiplicand[WIDTH-1];
        mplier_load_s = {{(EXT-WIDTH){mplier_ext_s}}, multiplier, 1'b0};
        mcand_load_s  = {{(MW-WIDTH){mcand_ext_s}}, multiplicand};
    end

    // The window always sits at the bottom of mplier_r; it is shifted down
    // each cycle while the multiplicand is shifted up by the same 2*DPC.
    for (genvar j = 0; j < DPC; j++) begin : g_digit
        booth_r4_digit #(
            .MW (MW)
        ) u_digit (
            .triplet (mplier_r[2*j+2 -: 3]),
            .mcand   (mcand_r),
            .pp      (pp_s[j])
        );
    end

    // Accumulate this cycle's DPC partial products, modulo 2^PW
    always_comb begin
        step_sum_s = acc_r;
        for (int j = 0; j < DPC; j++) begin
            step_sum_s = step_sum_s + PW'(pp_s[j] << (2 * j));
        end
    end

    // Next-state logic; op_clear overrides every transition
    always_comb begin
        state_next_s = state_r;
        if (op_clear) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (op_start) begin
                        state_next_s = ST_EXECUTE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_EXECUTE: begin
                    if (cnt_r == LAST_CNT) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_EXECUTE;
                    end
                end
                ST_DONE:    state_next_s = ST_DONE;
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, counter and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= '0;
            mplier_r <= '0;
            mcand_r  <= '0;
            acc_r    <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else if (op_clear) begin
            cnt_r    <= '0;
            acc_r    <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            // Flags follow the state one edge later, which keeps them disjoint
            done_r <= (state_r == ST_DONE);
            busy_r <= (state_r == ST_EXECUTE);
            case (state_r)
                ST_IDLE: begin
                    if (op_start) begin
                        mplier_r <= mplier_load_s;
                        mcand_r  <= mcand_load_s;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                    end
                end
                ST_EXECUTE: begin
                    acc_r    <= step_sum_s;
                    mplier_r <= mplier_r >> (2 * DPC);
                    mcand_r  <= mcand_r << (2 * DPC);
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                ST_DONE: begin
                    result_r <= acc_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign op_done = done_r;
    assign op_busy = busy_r;
    assign result  = result_r;

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Self-checking bench: directed cases and randomized operands for a 64x64/DPC=1
// and a 32x32/DPC=4 instance, checked against an arithmetic reference model.
module tb_booth_multiplier_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         a_start, a_clear, a_sm, a_done, a_busy;
    logic [63:0]  a_mpl, a_mcd;
    logic [127:0] a_res;
    logic         b_start, b_clear, b_sm, b_done, b_busy;
    logic [31:0]  b_mpl, b_mcd;
    logic [63:0]  b_res;

    int n_checks = 0;
    int n_pass   = 0;

    booth_multiplier_param #(.WIDTH(64), .DPC(1)) u_dut_a (
        .clk (clk), .reset (reset), .op_start (a_start), .op_clear (a_clear),
        .signed_mode (a_sm), .multiplier (a_mpl), .multiplicand (a_mcd),
        .op_done (a_done), .op_busy (a_busy), .result (a_res)
    );

    booth_multiplier_param #(.WIDTH(32), .DPC(4)) u_dut_b (
        .clk (clk), .reset (reset), .op_start (b_start), .op_clear (b_clear),
        .signed_mode (b_sm), .multiplier (b_mpl), .multiplicand (b_mcd),
        .op_done (b_done), .op_busy (b_busy), .result (b_res)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact product of w-bit operands, low 2w bits
    function automatic logic [127:0] model_product(input logic [63:0] x, input logic [63:0] m,
                                                   input bit sm, input int w);
        logic [127:0] ex, em, p;
        ex = {64'd0, x};
        em = {64'd0, m};
        if (sm && x[w-1]) ex = ex | (~128'd0 << w);
        if (sm && m[w-1]) em = em | (~128'd0 << w);
        p = ex * em;
        if (w < 64) p = p & ((128'd1 << (2 * w)) - 128'd1);
        return p;
    endfunction

    function automatic logic [63:0] rand_operand(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = {$urandom, $urandom};
            1:       v = 64'($urandom_range(0, 15));
            2:       v = $urandom_range(0, 1) ? ~64'd0 : (64'd1 << (w - 1));
            default: v = ~64'd0 - 64'($urandom_range(0, 15));
        endcase
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        return v;
    endfunction

    function automatic logic get_done(input int which);
        return (which == 1) ? b_done : a_done;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 1) ? b_busy : a_busy;
    endfunction

    function automatic logic [127:0] get_res(input int which);
        return (which == 1) ? {64'd0, b_res} : a_res;
    endfunction

    task automatic drive(input int which, input logic start, input logic clear, input logic sm,
                         input logic [63:0] x, input logic [63:0] m);
        if (which == 1) begin
            b_start = start; b_clear = clear; b_sm = sm; b_mpl = x[31:0]; b_mcd = m[31:0];
        end else begin
            a_start = start; a_clear = clear; a_sm = sm; a_mpl = x; a_mcd = m;
        end
    endtask

    // Called just after the edge that sampled op_start; counts edges until op_done
    task automatic wait_done(input int which, output logic [127:0] res, output int lat,
                             output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) drive(which, 1'b0, 1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                              {$urandom, $urandom});
            check("done_busy_excl", {127'd0, get_done(which) & get_busy(which)}, 128'd0);
            if (get_busy(which)) busy_cycles++;
            if (get_done(which)) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 128'd0, 128'd1);
        res = get_res(which);
    endtask

    task automatic do_op(input int which, input logic [63:0] x, input logic [63:0] m, input bit sm,
                         output logic [127:0] res, output int lat, output int busy_cycles);
        @(negedge clk);
        drive(which, 1'b1, 1'b0, sm, x, m);
        @(posedge clk);
        wait_done(which, res, lat, busy_cycles);
    endtask

    task automatic clear_op(input int which, input string tag);
        @(negedge clk);
        drive(which, 1'b0, 1'b1, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        check({tag, "_clr_res"}, get_res(which), 128'd0);
        check({tag, "_clr_done"}, {127'd0, get_done(which)}, 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        int           lat, bc;
        logic [63:0]  x, m;
        bit           sm;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        check("rst_done", {127'd0, a_done}, 128'd0);
        check("rst_busy", {127'd0, a_busy}, 128'd0);
        check("rst_res", a_res, 128'd0);
        reset = 1'b0;

        do_op(0, 64'd6, -64'sd6, 1'b1, res, lat, bc);
        check("s6xm6", res, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFDC);
        check("s6xm6_lat", 128'(lat), 128'd34);
        check("s6xm6_busy", 128'(bc), 128'd33);
        clear_op(0, "s6xm6");

        do_op(0, -64'sd15, -64'sd15, 1'b1, res, lat, bc);
        check("m15xm15", res, 128'hE1);
        clear_op(0, "m15");

        do_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, res, lat, bc);
        check("min_x_min", res, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
        clear_op(0, "min");

        do_op(0, ~64'd0, ~64'd0, 1'b0, res, lat, bc);
        check("u_ones", res, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        clear_op(0, "u_ones");
        do_op(0, ~64'd0, ~64'd0, 1'b1, res, lat, bc);
        check("s_ones", res, 128'h1);
        clear_op(0, "s_ones");

        do_op(0, 64'hA7D2, 64'd5, 1'b0, res, lat, bc);
        check("a7d2x5", res, 128'h3471A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 1'(i % 2), 1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        end
        @(negedge clk);
        check("hold_res", a_res, 128'h3471A);
        check("hold_done", {127'd0, a_done}, 128'd1);
        clear_op(0, "a7d2");
        check("a7d2_clr_busy", {127'd0, a_busy}, 128'd0);

        // Abort mid-EXECUTE with op_start held high, then restart on 3x7
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b1, 64'd100, 64'd200);
        @(posedge clk);
        repeat (4) @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 64'd3, 64'd7);
        @(negedge clk);
        check("abort_busy", {127'd0, a_busy}, 128'd0);
        check("abort_done", {127'd0, a_done}, 128'd0);
        drive(0, 1'b1, 1'b0, 1'b1, 64'd3, 64'd7);
        @(posedge clk);
        wait_done(0, res, lat, bc);
        check("restart_3x7", res, 128'd21);
        check("restart_lat", 128'(lat), 128'd34);
        clear_op(0, "restart");

        // Simultaneous op_start and op_clear in IDLE
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 64'd9, 64'd9);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        check("startclr_busy", {127'd0, a_busy}, 128'd0);
        check("startclr_done", {127'd0, a_done}, 128'd0);

        // Reset mid-EXECUTE
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 64'd11, 64'd13);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", {127'd0, a_busy}, 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", {127'd0, a_busy}, 128'd0);
        check("mid_rst_done", {127'd0, a_done}, 128'd0);
        check("mid_rst_res", a_res, 128'd0);
        repeat (2) @(negedge clk);
        check("post_rst_busy", {127'd0, a_busy}, 128'd0);

        for (int i = 0; i < 20; i++) begin
            x  = rand_operand(64);
            m  = rand_operand(64);
            sm = 1'($urandom_range(0, 1));
            do_op(0, x, m, sm, res, lat, bc);
            check($sformatf("rand_a%0d", i), res, model_product(x, m, sm, 64));
            check($sformatf("rand_a%0d_lat", i), 128'(lat), 128'd34);
            clear_op(0, "rand_a");
        end

        do_op(1, 64'h8000_0000, 64'h7FFF_FFFF, 1'b1, res, lat, bc);
        check("b_signed", res, 128'hC000_0000_8000_0000);
        check("b_lat", 128'(lat), 128'd6);
        check("b_busy", 128'(bc), 128'd5);
        clear_op(1, "b_signed");
        do_op(1, 64'h8000_0000, 64'h7FFF_FFFF, 1'b0, res, lat, bc);
        check("b_unsigned", res, 128'h3FFF_FFFF_8000_0000);
        clear_op(1, "b_unsigned");

        for (int i = 0; i < 15; i++) begin
            x  = rand_operand(32);
            m  = rand_operand(32);
            sm = 1'($urandom_range(0, 1));
            do_op(1, x, m, sm, res, lat, bc);
            check($sformatf("rand_b%0d", i), res, model_product(x, m, sm, 32));
            check($sformatf("rand_b%0d_lat", i), 128'(lat), 128'd6);
            clear_op(1, "rand_b");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
